core_mmu_bus_arb: RTL

//  - Stage directly downstream of the MMU. Merges the MMU's physical instruction-fetch and data ports onto the single core bus master port.
//  - Each port holds at most one pending request. One bus transaction is outstanding at a time.
//  - Grants are round-robin, or fixed data priority. Read data and the ready pulse go back to the requesting port only.

---
 rtl/core_mmu_bus_arb_pkg.sv | 23 ++
 rtl/core_mmu_bus_arb_if.sv | 45 ++++
 rtl/core_mmu_bus_arb_port.sv | 50 +++++
 rtl/core_mmu_bus_arb.sv | 115 +++++++++++
 4 files changed

// File: rtl/core_mmu_bus_arb_pkg.sv
// Shared types for the MMU-to-core-bus arbiter: address/data words, FSM states
// and the bundled request that is captured per port and driven onto the bus.
package core_mmu_bus_arb_pkg;

  typedef logic [29:0] ptr;
  typedef logic [31:0] word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INSN = 2'd1,
    DATA = 2'd2
  } mmu_arb_state;

  typedef struct packed {
    ptr         addr;
    logic       write;
    word        wr;
    logic [3:0] be;
  } bus_req_t;

  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/core_mmu_bus_arb_if.sv
// Bundles the fetch port, the data port and the core bus master port.
// slave is the arbiter's view; master is the MMU-plus-bus-slave environment.
interface core_mmu_bus_arb_if;
  import core_mmu_bus_arb_pkg::*;

  ptr         insn_addr;
  logic       insn_start;
  logic       insn_ready;
  word        insn_data_rd;

  ptr         data_addr;
  logic       data_start;
  logic       data_write;
  word        data_data_wr;
  logic [3:0] data_data_be;
  logic       data_ready;
  word        data_data_rd;

  ptr         bus_addr;
  logic       bus_start;
  logic       bus_write;
  word        bus_data_wr;
  logic [3:0] bus_data_be;
  logic       bus_ready;
  word        bus_data_rd;

  modport slave (
    input  insn_addr, insn_start,
    output insn_ready, insn_data_rd,
    input  data_addr, data_start, data_write, data_data_wr, data_data_be,
    output data_ready, data_data_rd,
    output bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be,
    input  bus_ready, bus_data_rd
  );

  modport master (
    output insn_addr, insn_start,
    input  insn_ready, insn_data_rd,
    output data_addr, data_start, data_write, data_data_wr, data_data_be,
    input  data_ready, data_data_rd,
    input  bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be,
    output bus_ready, bus_data_rd
  );

endinterface

// File: rtl/core_mmu_bus_arb_port.sv
// One requester slot: pending flag plus the captured request. A start in the
// current cycle is presented immediately so it can be granted without delay.
module core_mmu_bus_arb_port
  import core_mmu_bus_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  ptr         addr,
  input  logic       write,
  input  word        wr,
  input  logic [3:0] be,
  input  logic       grant,
  output logic       req,
  output bus_req_t   req_fields
);

  logic     pending_reg;
  logic     pending_next;
  bus_req_t cap_reg;
  bus_req_t start_fields;

  assign start_fields = '{addr: addr, write: write, wr: wr, be: be};

  // A start that is granted in the same cycle is consumed and never becomes pending.
  always_comb begin
    pending_next = pending_reg;
    if (start) begin
      pending_next = !grant;
    end else if (grant) begin
      pending_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg <= 1'b0;
      cap_reg     <= '0;
    end else begin
      pending_reg <= pending_next;
      if (start) begin
        cap_reg <= start_fields;
      end
    end
  end

  assign req        = pending_reg | start;
  assign req_fields = start ? start_fields : cap_reg;

endmodule

// File: rtl/core_mmu_bus_arb.sv
// Merges the MMU fetch and data ports onto one core bus master with a single
// outstanding transaction; round-robin (FAIR=1) or data-first (FAIR=0) grants.
module core_mmu_bus_arb
  import core_mmu_bus_arb_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input logic              clk,
  input logic              rst,
  core_mmu_bus_arb_if.slave io
);

  mmu_arb_state state_reg, state_next;
  mmu_arb_state last_grant_reg, last_grant_next;

  logic     insn_req, data_req;
  bus_req_t insn_fields, data_fields;
  logic     grant_insn, grant_data;
  logic     can_grant, pick_data;

  bus_req_t bus_reg;
  logic     bus_start_reg;
  logic     insn_ready_reg, data_ready_reg;
  word      insn_rd_reg, data_rd_reg;

  core_mmu_bus_arb_port u_insn_port (
    .clk        (clk),
    .rst        (rst),
    .start      (io.insn_start),
    .addr       (io.insn_addr),
    .write      (1'b0),
    .wr         (32'h0),
    .be         (BE_WORD),
    .grant      (grant_insn),
    .req        (insn_req),
    .req_fields (insn_fields)
  );

  core_mmu_bus_arb_port u_data_port (
    .clk        (clk),
    .rst        (rst),
    .start      (io.data_start),
    .addr       (io.data_addr),
    .write      (io.data_write),
    .wr         (io.data_data_wr),
    .be         (io.data_data_be),
    .grant      (grant_data),
    .req        (data_req),
    .req_fields (data_fields)
  );

  // A grant happens from IDLE or on the completing cycle of the current owner.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_insn      = 1'b0;
    grant_data      = 1'b0;
    can_grant       = (state_reg == IDLE) || io.bus_ready;
    pick_data       = data_req && (!insn_req || !FAIR || (last_grant_reg == INSN));
    if (can_grant && (insn_req || data_req)) begin
      if (pick_data) begin
        grant_data      = 1'b1;
        state_next      = DATA;
        last_grant_next = DATA;
      end else begin
        grant_insn      = 1'b1;
        state_next      = INSN;
        last_grant_next = INSN;
      end
    end else if ((state_reg != IDLE) && io.bus_ready) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= INSN;
      bus_reg        <= '0;
      bus_start_reg  <= 1'b0;
      insn_ready_reg <= 1'b0;
      data_ready_reg <= 1'b0;
      insn_rd_reg    <= '0;
      data_rd_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      bus_start_reg  <= grant_insn | grant_data;
      if (grant_data) begin
        bus_reg <= data_fields;
      end else if (grant_insn) begin
        bus_reg <= insn_fields;
      end
      insn_ready_reg <= io.bus_ready && (state_reg == INSN);
      data_ready_reg <= io.bus_ready && (state_reg == DATA);
      if (io.bus_ready && (state_reg == INSN)) begin
        insn_rd_reg <= io.bus_data_rd;
      end
      if (io.bus_ready && (state_reg == DATA)) begin
        data_rd_reg <= io.bus_data_rd;
      end
    end
  end

  assign io.bus_addr     = bus_reg.addr;
  assign io.bus_write    = bus_reg.write;
  assign io.bus_data_wr  = bus_reg.wr;
  assign io.bus_data_be  = bus_reg.be;
  assign io.bus_start    = bus_start_reg;
  assign io.insn_ready   = insn_ready_reg;
  assign io.insn_data_rd = insn_rd_reg;
  assign io.data_ready   = data_ready_reg;
  assign io.data_data_rd = data_rd_reg;

endmodule
